// File: rtl/stream_router_pkg.sv
`timescale 1ns/1ps
// stream_router_pkg
// Shared definitions for the stream router and its per-port FIFOs:
//   addr_w()          - width of the destination address for a given port count
//   ptr_w()           - FIFO pointer width for a given (power of 2) depth
//   DEFAULT_PTR_W     - pointer width for the default FIFO depth
//   fifo_status_t     - per-port FIFO status {full, empty}
package stream_router_pkg;

  // At least one address bit, even for a 2-port router.
  function automatic int addr_w(input int num_ports);
    return (num_ports <= 2) ? 1 : $clog2(num_ports);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_PTR_W      = ptr_w(DEFAULT_FIFO_DEPTH);

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_status_t;

endpackage

// File: rtl/router_fifo.sv
`timescale 1ns/1ps
// router_fifo
// Single-clock synchronous FIFO holding the words queued for one output port.
// The head word is presented combinationally on rdata, so a word pushed at
// edge N is visible right after edge N.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (empties the FIFO)
//   push, wdata - write request and data; ignored while full
//   pop         - read request; ignored while empty
//   rdata       - head word (contents undefined while empty)
//   full, empty - status from registered count only
module router_fifo
  import stream_router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = ptr_w(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    empty    = (count_q == '0);
    // No bypass: a push into a full FIFO is refused even if it pops this cycle.
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/stream_router.sv
`timescale 1ns/1ps
// stream_router
// Routes one valid/ready input stream to NUM_PORTS output streams, each with
// its own FIFO, so a stalled consumer only blocks traffic addressed to it.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   din, din_valid        - input word and its valid
//   din_ready             - input can be accepted (from FIFO state only)
//   addr, bcast           - destination port, or all ports when bcast is high
//   dout, dout_valid      - flattened per-port head word (0 when empty), valid
//   dout_ready            - per-port consumer ready
//   addr_err              - sticky: an out-of-range unicast word was accepted
module stream_router
  import stream_router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_W    = addr_w(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            din_valid,
  output logic                            din_ready,
  input  logic [ADDR_W-1:0]               addr,
  input  logic                            bcast,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]            dout_valid,
  input  logic [NUM_PORTS-1:0]            dout_ready,
  output logic                            addr_err
);

  logic [NUM_PORTS-1:0]  full_vec, empty_vec, hit, push, pop;
  logic [DATA_WIDTH-1:0] rdata [NUM_PORTS];
  fifo_status_t          stat  [NUM_PORTS];
  logic                  addr_ok, any_full, sel_full, accept;
  logic                  addr_err_q, addr_err_d;

  // When the port count fills the address space every address is legal;
  // skipping the compare avoids a constant comparison.
  generate
    if (NUM_PORTS == (1 << ADDR_W)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (addr < ADDR_W'(NUM_PORTS));
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign hit[gi] = (addr == ADDR_W'(gi));

      router_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .wdata (din),
        .rdata (rdata[gi]),
        .full  (full_vec[gi]),
        .empty (empty_vec[gi])
      );

      assign pop[gi]        = dout_ready[gi] && !empty_vec[gi];
      assign dout_valid[gi] = !empty_vec[gi];
      // Empty ports read as zero, like unselected outputs of the old router.
      assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = empty_vec[gi] ? '0 : rdata[gi];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      stat[i] = '{full: full_vec[i], empty: empty_vec[i]};
    end
  end

  always_comb begin
    any_full = 1'b0;
    sel_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      any_full |= stat[i].full;
      if (hit[i]) sel_full |= stat[i].full;
    end

    // Broadcast waits until every FIFO has room, so delivery is all-or-none.
    // Out-of-range unicast words are always taken and dropped.
    if (bcast)         din_ready = !any_full;
    else if (!addr_ok) din_ready = 1'b1;
    else               din_ready = !sel_full;

    accept = din_valid && din_ready;
    for (int i = 0; i < NUM_PORTS; i++) begin
      push[i] = accept && (bcast || hit[i]);
    end

    addr_err_d = addr_err_q || (accept && !bcast && !addr_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) addr_err_q <= 1'b0;
    else       addr_err_q <= addr_err_d;
  end

  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_stream_router.sv
`timescale 1ns/1ps
// tb_stream_router
// Directed tests for stream_router: a 4-port instance for the main features
// and a 3-port instance for the out-of-range address flag.
module tb_stream_router;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 4-port instance
  logic [31:0]  din;
  logic         din_valid, din_ready, bcast, addr_err;
  logic [1:0]   addr;
  logic [127:0] dout;
  logic [3:0]   dout_valid, dout_ready;

  // 3-port instance
  logic [31:0]  din3;
  logic         din_valid3, din_ready3, bcast3, addr_err3;
  logic [1:0]   addr3;
  logic [95:0]  dout3;
  logic [2:0]   dout_valid3, dout_ready3;

  int n_checks = 0;
  int n_fail   = 0;

  stream_router #(.DATA_WIDTH(32), .NUM_PORTS(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .addr(addr), .bcast(bcast), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .addr_err(addr_err)
  );

  stream_router #(.DATA_WIDTH(32), .NUM_PORTS(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .din(din3), .din_valid(din_valid3),
    .din_ready(din_ready3), .addr(addr3), .bcast(bcast3), .dout(dout3),
    .dout_valid(dout_valid3), .dout_ready(dout_ready3), .addr_err(addr_err3)
  );

  // One line per accepted input word (inputs are stable at the falling edge).
  always @(negedge clk) begin
    if (!reset && din_valid && din_ready)
      $display("xfer dut  addr=%0d bcast=%0d data=%h", addr, bcast, din);
    if (!reset && din_valid3 && din_ready3)
      $display("xfer dut3 addr=%0d bcast=%0d data=%h", addr3, bcast3, din3);
  end

  function automatic logic [31:0] pd(input int p);
    return dout[p*32 +: 32];
  endfunction

  // Advance past the next rising edge; inputs change and outputs are read here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    din = '0; din_valid = 0; addr = '0; bcast = 0; dout_ready = '0;
    din3 = '0; din_valid3 = 0; addr3 = '0; bcast3 = 0; dout_ready3 = '0;
    reset = 1;
    step(); step();
    reset = 0;
    #1;
    n_checks++; if (dout_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected %b", dout_valid, 4'b0000); end
    n_checks++; if (dout !== 128'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready: got %b expected 1", din_ready); end
    n_checks++; if (addr_err3 !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err3: got %b expected 0", addr_err3); end
  endtask

  task automatic test_unicast_latency();
    din = 32'hDEADBEEF; addr = 2'd2; din_valid = 1;
    step();
    din_valid = 0;
    #1;
    n_checks++; if (dout_valid !== 4'b0100) begin n_fail++; $display("FAIL uni_valid: got %b expected %b", dout_valid, 4'b0100); end
    n_checks++; if (pd(2) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL uni_data: got %h expected %h", pd(2), 32'hDEADBEEF); end
    n_checks++; if ((dout & ~{32'h0, 32'hFFFFFFFF, 64'h0}) !== 128'h0) begin n_fail++; $display("FAIL uni_others_zero: got %h expected 0 outside port 2", dout); end
    step(); step(); step();
    n_checks++; if (dout_valid !== 4'b0100 || pd(2) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL uni_hold: got %b/%h expected 0100/deadbeef", dout_valid, pd(2)); end
    dout_ready = 4'b0100;
    step();
    dout_ready = 4'b0000;
    #1;
    n_checks++; if (dout_valid !== 4'b0000) begin n_fail++; $display("FAIL uni_popped: got %b expected %b", dout_valid, 4'b0000); end
    n_checks++; if (dout !== 128'h0) begin n_fail++; $display("FAIL uni_popped_zero: got %h expected 0", dout); end
  endtask

  task automatic test_backpressure();
    dout_ready = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      din = k; addr = 2'd1; din_valid = 1;
      #1;
      n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready_%0d: got %b expected 1", k, din_ready); end
      step();
    end
    din = 32'h5; addr = 2'd1;
    #1;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", din_ready); end
    din = 32'h33; addr = 2'd3;
    #1;
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready: got %b expected 1", din_ready); end
    step();
    din_valid = 0;
    #1;
    n_checks++; if (dout_valid !== 4'b1010) begin n_fail++; $display("FAIL bp_valid: got %b expected %b", dout_valid, 4'b1010); end
    dout_ready = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (pd(1) !== 32'(k)) begin n_fail++; $display("FAIL bp_order_%0d: got %h expected %h", k, pd(1), 32'(k)); end
      step();
    end
    dout_ready = 4'b1000;
    #1;
    n_checks++; if (dout_valid !== 4'b1000 || pd(3) !== 32'h33) begin n_fail++; $display("FAIL bp_port3: got %b/%h expected 1000/00000033", dout_valid, pd(3)); end
    step();
    dout_ready = 4'b0000;
    #1;
    n_checks++; if (dout_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_drained: got %b expected %b", dout_valid, 4'b0000); end
  endtask

  task automatic test_push_pop_full();
    dout_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      din = 32'h10 + k; addr = 2'd0; din_valid = 1;
      step();
    end
    din = 32'h14; dout_ready = 4'b0001;
    #1;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL ppf_blocked: got %b expected 0", din_ready); end
    n_checks++; if (pd(0) !== 32'h10) begin n_fail++; $display("FAIL ppf_head0: got %h expected %h", pd(0), 32'h10); end
    step();
    dout_ready = 4'b0000;
    #1;
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL ppf_ready_after_pop: got %b expected 1", din_ready); end
    n_checks++; if (pd(0) !== 32'h11) begin n_fail++; $display("FAIL ppf_head1: got %h expected %h", pd(0), 32'h11); end
    step();
    din_valid = 0;
    #1;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL ppf_full_again: got %b expected 0", din_ready); end
    dout_ready = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (pd(0) !== 32'h10 + 32'(k)) begin n_fail++; $display("FAIL ppf_drain_%0d: got %h expected %h", k, pd(0), 32'h10 + 32'(k)); end
      step();
    end
    dout_ready = 4'b0000;
    #1;
    n_checks++; if (dout_valid !== 4'b0000) begin n_fail++; $display("FAIL ppf_empty: got %b expected %b", dout_valid, 4'b0000); end
  endtask

  task automatic test_broadcast();
    dout_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      din = 32'h30 + k; addr = 2'd3; din_valid = 1;
      step();
    end
    din = 32'hA5A5A5A5; bcast = 1; addr = 2'd0;
    #1;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL bc_blocked: got %b expected 0", din_ready); end
    step();
    n_checks++; if (dout_valid !== 4'b1000 || pd(3) !== 32'h30) begin n_fail++; $display("FAIL bc_no_change: got %b/%h expected 1000/00000030", dout_valid, pd(3)); end
    dout_ready = 4'b1000;
    #1;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL bc_blocked_during_pop: got %b expected 0", din_ready); end
    step();
    dout_ready = 4'b0000;
    #1;
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL bc_ready: got %b expected 1", din_ready); end
    step();
    din_valid = 0; bcast = 0;
    #1;
    n_checks++; if (dout_valid !== 4'b1111) begin n_fail++; $display("FAIL bc_valid: got %b expected %b", dout_valid, 4'b1111); end
    n_checks++; if (pd(0) !== 32'hA5A5A5A5 || pd(1) !== 32'hA5A5A5A5 || pd(2) !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bc_data: got %h expected a5a5a5a5 on ports 0..2", dout); end
    n_checks++; if (pd(3) !== 32'h31) begin n_fail++; $display("FAIL bc_port3_head: got %h expected %h", pd(3), 32'h31); end
    dout_ready = 4'b1111;
    step();
    dout_ready = 4'b1000;
    #1;
    n_checks++; if (dout_valid !== 4'b1000 || pd(3) !== 32'h32) begin n_fail++; $display("FAIL bc_drain1: got %b/%h expected 1000/00000032", dout_valid, pd(3)); end
    step(); step();
    n_checks++; if (pd(3) !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bc_port3_last: got %h expected %h", pd(3), 32'hA5A5A5A5); end
    step();
    dout_ready = 4'b0000;
    #1;
    n_checks++; if (dout_valid !== 4'b0000) begin n_fail++; $display("FAIL bc_empty: got %b expected %b", dout_valid, 4'b0000); end
  endtask

  task automatic test_addr_err();
    din3 = 32'h77; addr3 = 2'd3; bcast3 = 0; din_valid3 = 1; dout_ready3 = 3'b000;
    #1;
    n_checks++; if (din_ready3 !== 1'b1) begin n_fail++; $display("FAIL ae_ready: got %b expected 1", din_ready3); end
    n_checks++; if (addr_err3 !== 1'b0) begin n_fail++; $display("FAIL ae_before: got %b expected 0", addr_err3); end
    step();
    din_valid3 = 0;
    #1;
    n_checks++; if (addr_err3 !== 1'b1) begin n_fail++; $display("FAIL ae_set: got %b expected 1", addr_err3); end
    n_checks++; if (dout_valid3 !== 3'b000) begin n_fail++; $display("FAIL ae_dropped: got %b expected %b", dout_valid3, 3'b000); end
    din3 = 32'h22; addr3 = 2'd2; din_valid3 = 1;
    step();
    din_valid3 = 0;
    step(); step();
    n_checks++; if (dout_valid3 !== 3'b100 || dout3[95:64] !== 32'h22) begin n_fail++; $display("FAIL ae_inrange: got %b/%h expected 100/00000022", dout_valid3, dout3[95:64]); end
    n_checks++; if (addr_err3 !== 1'b1) begin n_fail++; $display("FAIL ae_sticky: got %b expected 1", addr_err3); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL ae_main_clear: got %b expected 0", addr_err); end
  endtask

  task automatic test_reset_mid();
    din = 32'h55; addr = 2'd0; din_valid = 1;
    step();
    reset = 1; din = 32'h56;
    step(); step();
    reset = 0; din_valid = 0;
    #1;
    n_checks++; if (dout_valid !== 4'b0000 || dout !== 128'h0) begin n_fail++; $display("FAIL rm_discard: got %b/%h expected 0000/0", dout_valid, dout); end
    n_checks++; if (dout_valid3 !== 3'b000) begin n_fail++; $display("FAIL rm_discard3: got %b expected %b", dout_valid3, 3'b000); end
    n_checks++; if (addr_err3 !== 1'b0) begin n_fail++; $display("FAIL rm_addr_err3: got %b expected 0", addr_err3); end
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b expected 1", din_ready); end
  endtask

  initial begin
    test_reset();
    test_unicast_latency();
    test_backpressure();
    test_push_pop_full();
    test_broadcast();
    test_addr_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_router.md
Name: stream_router

Overview:
- Parametrised successor of the 1-to-4 combinational address router.
- Routes one input word stream to NUM_PORTS output streams, selected by addr.
- Each output has its own FIFO and valid/ready handshake, so one stalled consumer back-pressures only traffic addressed to it.
- Adds a broadcast mode, plus a sticky error for addresses beyond NUM_PORTS. Sits between a packet source and per-channel consumers.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- NUM_PORTS, 4, number of output channels. Legal range 2..16.
- FIFO_DEPTH, 4, words per output FIFO. Power of 2, at least 2.

Ports:
- clk  input  1  Single clock; all logic is on the rising edge.
- reset  input  1  Synchronous, active-high reset.
- din  input  DATA_WIDTH  Input word.
- din_valid  input  1  Input word is valid.
- din_ready  output  1  Router can accept the current word.
- addr  input  ADDR_W  Destination port index. ADDR_W = max(1, $clog2(NUM_PORTS)).
- bcast  input  1  When high, the word goes to every port and addr is ignored.
- dout  output  NUM_PORTS*DATA_WIDTH  Flattened; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- dout_valid  output  NUM_PORTS  Per-port head-of-FIFO valid.
- dout_ready  input  NUM_PORTS  Per-port consumer ready.
- addr_err  output  1  Sticky flag: an out-of-range unicast word was accepted.

Behaviour:
- Reset:
  - All FIFOs empty; dout_valid = 0; dout = 0; addr_err = 0.
  - Reset has priority over every concurrent push or pop.
  - Reset asserted mid-transfer discards all stored words.
- Handshake:
  - A transfer happens on a cycle where valid and ready are both high.
  - din and addr may change only after a transfer, or while din_valid is low.
- din_ready is combinational from registered FIFO state only, never from dout_ready:
  - Unicast, addr < NUM_PORTS: din_ready = !full[addr].
  - Unicast, addr >= NUM_PORTS: din_ready = 1. The word is accepted, dropped, and addr_err is set on the next cycle.
  - Broadcast: din_ready = no FIFO full. On accept, the word is pushed into every FIFO in the same cycle. There is no partial delivery.
- Push while full is blocked even if that FIFO is popped in the same cycle. There is no same-cycle bypass.
- Latency:
  - A word accepted at edge N appears on dout_valid/dout of its port after edge N (1 cycle).
  - There is no combinational path from din to dout.
- Output:
  - dout_valid[i] = FIFO i non-empty.
  - dout for port i shows the head word while valid and holds it stable until popped.
  - dout for port i reads 0 while that FIFO is empty (the old router zeroed unselected outputs; same convention).
- Per FIFO:
  - Simultaneous push and pop while non-empty and non-full: count unchanged, pointers both advance.
  - Push and pop on an empty FIFO: push only; the pop is impossible because valid is low.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Ordering:
  - Per-port order equals input acceptance order.
  - No ordering is defined between different ports.
- addr_err clears only on reset.

Decomposition:
- Shared package stream_router_pkg:
  - Function to compute ADDR_W from NUM_PORTS.
  - Localparam for the pointer width derived from FIFO_DEPTH.
  - Typedef for the per-port FIFO status struct {full, empty}.
- Sub-module router_fifo:
  - Synchronous FIFO, single clock, same reset.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Instantiated NUM_PORTS times in a generate loop.
- The top level holds only address decode, broadcast gating, addr_err and output zeroing.

Test Plan:
- Reset then idle: drive reset high for 2 cycles → dout_valid = 0000, dout = 0, addr_err = 0, din_ready = 1.
- Unicast latency: din = 0xDEADBEEF, addr = 2, valid for 1 cycle, all dout_ready = 0 → next cycle dout_valid = 0100 and port 2 data = 0xDEADBEEF. It holds there until dout_ready[2] = 1 for one cycle, after which dout_valid = 0000.
- Back-pressure and isolation: with dout_ready[1] = 0, push 0x1..0x4 to port 1 → din_ready falls to 0 for addr = 1 after the 4th word. addr = 3 is still accepted. Draining port 1 yields 0x1, 0x2, 0x3, 0x4 in order.
- Simultaneous push/pop at full:
  - Port 0 full, dout_ready[0] = 1, din_valid with addr = 0 → din_ready = 0 that cycle and one word is popped.
  - Next cycle din_ready = 1; the new word is accepted and the count returns to 4.
- Broadcast gating:
  - Port 3 full, then bcast = 1 with din = 0xA5A5A5A5 → din_ready = 0 and no FIFO changes.
  - After one pop on port 3, the word is accepted and appears on all 4 ports the following cycle.
- Out-of-range address: NUM_PORTS = 3, addr = 3, din_valid = 1 → accepted, no dout_valid asserted, addr_err = 1 next cycle. It stays 1 until reset.
